// File: rtl/iir_pkg.sv
// Shared types and constants for the biquad cascade: FSM states and coefficient layout.
package iir_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StRound,
        StOut
    } iir_state_e;

    localparam int unsigned COEFFS_PER_SECTION = 5;

    // Coefficient index within a section; doubles as the MAC step counter value.
    localparam logic [2:0] B0 = 3'd0;
    localparam logic [2:0] B1 = 3'd1;
    localparam logic [2:0] B2 = 3'd2;
    localparam logic [2:0] A1 = 3'd3;
    localparam logic [2:0] A2 = 3'd4;

endpackage

// File: rtl/iir_biquad_cascade_if.sv
// Sample stream, result and coefficient-port signals of the biquad cascade.
interface iir_biquad_cascade_if #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned COEFF_WIDTH  = 20,
    parameter int unsigned NUM_SECTIONS = 3
);
    localparam int unsigned ADDR_WIDTH = $clog2(iir_pkg::COEFFS_PER_SECTION * NUM_SECTIONS);

    logic                   valid_in;
    logic                   ready;
    logic                   bypass;
    logic [DATA_WIDTH-1:0]  iir_in;
    logic                   coeff_wr_en;
    logic [ADDR_WIDTH-1:0]  coeff_addr;
    logic [COEFF_WIDTH-1:0] coeff_data;
    logic [COEFF_WIDTH-1:0] coeff_rd_data;
    logic                   coeff_wr_err;
    logic [DATA_WIDTH-1:0]  iir_out;
    logic                   valid_out;
    logic                   overflow;
    logic                   underflow;

    modport master (
        output valid_in, bypass, iir_in, coeff_wr_en, coeff_addr, coeff_data,
        input  ready, coeff_rd_data, coeff_wr_err, iir_out, valid_out, overflow, underflow
    );

    modport slave (
        input  valid_in, bypass, iir_in, coeff_wr_en, coeff_addr, coeff_data,
        output ready, coeff_rd_data, coeff_wr_err, iir_out, valid_out, overflow, underflow
    );

endinterface

// File: rtl/iir_round_sat.sv
// Round-half-up, drop fraction bits and saturate an accumulator to the sample width.
module iir_round_sat #(
    parameter int unsigned ACC_WIDTH  = 39,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned COEFF_FRAC = 18
) (
    input  logic signed [ACC_WIDTH-1:0]  acc,
    output logic signed [DATA_WIDTH-1:0] data,
    output logic                         overflow,
    output logic                         underflow
);
    localparam logic signed [ACC_WIDTH-1:0] HALF =
        {{(ACC_WIDTH-1){1'b0}}, 1'b1} << (COEFF_FRAC - 1);
    localparam logic signed [ACC_WIDTH-1:0] DMAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] DMIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH-1:0] shifted;

    always_comb begin
        shifted   = (acc + HALF) >>> COEFF_FRAC;
        overflow  = shifted > DMAX;
        underflow = shifted < DMIN;
        data      = shifted[DATA_WIDTH-1:0];
        if (overflow) begin
            data = DMAX[DATA_WIDTH-1:0];
        end else if (underflow) begin
            data = DMIN[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/iir_biquad_cascade.sv
// Cascade of direct-form-I biquads sharing one multiplier, one product per cycle.
// Define IIR_SAT_CNT_EN to add the sat_count port counting saturated samples.
module iir_biquad_cascade
    import iir_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned DATA_FRAC    = 15,
    parameter int unsigned COEFF_WIDTH  = 20,
    parameter int unsigned COEFF_FRAC   = 18,
    parameter int unsigned NUM_SECTIONS = 3
) (
    input logic                 clk,
    input logic                 rst,
    iir_biquad_cascade_if.slave bus
`ifdef IIR_SAT_CNT_EN
    ,
    output logic [15:0]         sat_count
`endif
);
    localparam int unsigned NUM_COEFFS = COEFFS_PER_SECTION * NUM_SECTIONS;
    localparam int unsigned CA_W       = $clog2(NUM_COEFFS);
    localparam int unsigned SEC_W      = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;
    localparam int unsigned PROD_W     = DATA_WIDTH + COEFF_WIDTH;
    localparam int unsigned ACC_W      = PROD_W + 3;
    // Products carry DATA_FRAC+COEFF_FRAC fraction bits; results keep the input's DATA_FRAC.
    localparam int unsigned ROUND_SHIFT = (DATA_FRAC + COEFF_FRAC) - DATA_FRAC;

    localparam logic signed [COEFF_WIDTH-1:0] COEFF_ONE =
        {{(COEFF_WIDTH-1){1'b0}}, 1'b1} << COEFF_FRAC;
    localparam logic [CA_W-1:0]  LAST_ADDR = CA_W'(NUM_COEFFS - 1);
    localparam logic [SEC_W-1:0] LAST_SEC  = SEC_W'(NUM_SECTIONS - 1);

    iir_state_e state_q, state_d;
    logic [2:0]       k_q, k_d;
    logic [SEC_W-1:0] sec_q, sec_d;

    logic signed [COEFF_WIDTH-1:0] coeff_q [NUM_COEFFS];
    logic signed [DATA_WIDTH-1:0]  x1_q [NUM_SECTIONS];
    logic signed [DATA_WIDTH-1:0]  x2_q [NUM_SECTIONS];
    logic signed [DATA_WIDTH-1:0]  y1_q [NUM_SECTIONS];
    logic signed [DATA_WIDTH-1:0]  y2_q [NUM_SECTIONS];

    logic signed [DATA_WIDTH-1:0] x_cur_q;
    logic signed [ACC_W-1:0]      acc_q, acc_d, acc_base;
    logic signed [PROD_W-1:0]     prod;
    logic signed [DATA_WIDTH-1:0] data_op;
    logic signed [COEFF_WIDTH-1:0] coeff_op;
    logic [CA_W-1:0]              mac_idx;

    logic signed [DATA_WIDTH-1:0] round_data;
    logic                         round_ovf, round_unf;

    logic                  ovf_q, unf_q;
    logic [DATA_WIDTH-1:0] iir_out_q, byp_data_q;
    logic                  valid_out_q, overflow_q, underflow_q, wr_err_q, byp_pend_q;
    logic                  ready, accept, rd_ok;

    // A bypass accepted in OUT is parked one cycle so it does not collide with the filtered result.
    assign ready  = ((state_q == StIdle) && !byp_pend_q) || (state_q == StOut);
    assign accept = bus.valid_in && ready;
    assign rd_ok  = bus.coeff_addr <= LAST_ADDR;

    assign bus.ready         = ready;
    assign bus.coeff_rd_data = rd_ok ? coeff_q[bus.coeff_addr] : '0;
    assign bus.coeff_wr_err  = wr_err_q;
    assign bus.iir_out       = iir_out_q;
    assign bus.valid_out     = valid_out_q;
    assign bus.overflow      = overflow_q;
    assign bus.underflow     = underflow_q;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        sec_d   = sec_q;
        unique case (state_q)
            StIdle, StOut: begin
                if (accept && !bus.bypass) begin
                    state_d = StMac;
                    k_d     = B0;
                    sec_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StMac: begin
                if (k_q == A2) begin
                    state_d = StRound;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            StRound: begin
                if (sec_q == LAST_SEC) begin
                    state_d = StOut;
                end else begin
                    state_d = StMac;
                    k_d     = B0;
                    sec_d   = sec_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            k_q     <= B0;
            sec_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            sec_q   <= sec_d;
        end
    end

    always_comb begin
        mac_idx  = CA_W'(int'(sec_q) * int'(COEFFS_PER_SECTION) + int'(k_q));
        coeff_op = coeff_q[mac_idx];
        case (k_q)
            B0:      data_op = x_cur_q;
            B1:      data_op = x1_q[sec_q];
            B2:      data_op = x2_q[sec_q];
            A1:      data_op = y1_q[sec_q];
            default: data_op = y2_q[sec_q];
        endcase
        prod = PROD_W'(data_op) * PROD_W'(coeff_op);
        if (k_q == B0) begin
            acc_base = '0;
        end else begin
            acc_base = acc_q;
        end
        if (k_q >= A1) begin
            acc_d = acc_base - ACC_W'(prod);
        end else begin
            acc_d = acc_base + ACC_W'(prod);
        end
    end

    iir_round_sat #(
        .ACC_WIDTH  (ACC_W),
        .DATA_WIDTH (DATA_WIDTH),
        .COEFF_FRAC (ROUND_SHIFT)
    ) u_round_sat (
        .acc       (acc_q),
        .data      (round_data),
        .overflow  (round_ovf),
        .underflow (round_unf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_COEFFS); i++) begin
                coeff_q[i] <= (i % int'(COEFFS_PER_SECTION) == 0) ? COEFF_ONE : '0;
            end
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= 1'b0;
            if (bus.coeff_wr_en) begin
                if (state_q != StIdle) begin
                    wr_err_q <= 1'b1;
                end else if (rd_ok) begin
                    coeff_q[bus.coeff_addr] <= bus.coeff_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < int'(NUM_SECTIONS); s++) begin
                x1_q[s] <= '0;
                x2_q[s] <= '0;
                y1_q[s] <= '0;
                y2_q[s] <= '0;
            end
            x_cur_q     <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            iir_out_q   <= '0;
            valid_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            byp_pend_q  <= 1'b0;
            byp_data_q  <= '0;
        end else begin
            valid_out_q <= 1'b0;
            if (byp_pend_q) begin
                iir_out_q   <= byp_data_q;
                overflow_q  <= 1'b0;
                underflow_q <= 1'b0;
                valid_out_q <= 1'b1;
                byp_pend_q  <= 1'b0;
            end
            if (accept) begin
                if (bus.bypass && (state_q == StOut)) begin
                    byp_pend_q <= 1'b1;
                    byp_data_q <= bus.iir_in;
                end else if (bus.bypass) begin
                    iir_out_q   <= bus.iir_in;
                    overflow_q  <= 1'b0;
                    underflow_q <= 1'b0;
                    valid_out_q <= 1'b1;
                end else begin
                    x_cur_q <= bus.iir_in;
                    ovf_q   <= 1'b0;
                    unf_q   <= 1'b0;
                end
            end
            if (state_q == StMac) begin
                acc_q <= acc_d;
            end
            if (state_q == StRound) begin
                x2_q[sec_q] <= x1_q[sec_q];
                x1_q[sec_q] <= x_cur_q;
                y2_q[sec_q] <= y1_q[sec_q];
                y1_q[sec_q] <= round_data;
                x_cur_q     <= round_data;
                ovf_q       <= ovf_q | round_ovf;
                unf_q       <= unf_q | round_unf;
            end
            if (state_q == StOut) begin
                iir_out_q   <= x_cur_q;
                overflow_q  <= ovf_q;
                underflow_q <= unf_q;
                valid_out_q <= 1'b1;
            end
        end
    end

`ifdef IIR_SAT_CNT_EN
    logic [15:0] sat_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count_q <= '0;
        end else if ((state_q == StOut) && (ovf_q || unf_q) && (sat_count_q != 16'hFFFF)) begin
            sat_count_q <= sat_count_q + 16'd1;
        end
    end

    assign sat_count = sat_count_q;
`endif

endmodule

// File: doc/iir_biquad_cascade.md
IIR_BIQUAD_CASCADE -- requirements
Module: iir_biquad_cascade

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, sample width (signed).
REQ-002 SHALL have parameter DATA_FRAC, default 15, sample fraction bits.
REQ-003 SHALL have parameter COEFF_WIDTH, default 20, coefficient width (signed).
REQ-004 SHALL have parameter COEFF_FRAC, default 18, coefficient fraction bits.
REQ-005 SHALL have parameter NUM_SECTIONS, default 3, number of cascaded biquads (1..8).
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port valid_in, input, 1, sample strobe, honoured only when ready is high.
REQ-009 SHALL have port ready, output, 1, high when idle and able to accept a sample.
REQ-010 SHALL have port bypass, input, 1, pass-through mode, sampled at accept.
REQ-011 SHALL have port iir_in, input, DATA_WIDTH, input sample.
REQ-012 SHALL have ports coeff_wr_en (input, 1), coeff_addr (input, $clog2(5*NUM_SECTIONS)) and coeff_data (input, COEFF_WIDTH), the coefficient write port.
REQ-013 SHALL have port coeff_rd_data, output, COEFF_WIDTH, combinational readback at coeff_addr.
REQ-014 SHALL have port coeff_wr_err, output, 1, one-cycle pulse when a write is rejected.
REQ-015 SHALL have ports iir_out (output, DATA_WIDTH), valid_out (output, 1), overflow (output, 1) and underflow (output, 1).

Function
REQ-016 SHALL order coefficients per section s at address 5s+k, with k = 0..4 for b0, b1, b2, a1, a2; addresses at or above 5*NUM_SECTIONS SHALL be ignored on write and read as 0.
REQ-017 SHALL compute per section: y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2, where y is the input x of section s+1.
REQ-018 SHALL use one shared multiplier, one product per cycle, with FSM states IDLE, MAC (k = 0..4), ROUND and OUT.
REQ-019 SHALL make these transitions:
- IDLE to MAC on accept (valid_in && ready && !bypass).
- MAC k=4 to ROUND.
- ROUND to MAC of the next section, or to OUT after the last section.
- OUT to IDLE.
REQ-020 SHALL use product width DATA_WIDTH+COEFF_WIDTH and accumulator width product+3 with no internal wrap, and SHALL clear the accumulator at each section start.
REQ-021 In ROUND, SHALL add 2^(COEFF_FRAC-1), arithmetic-shift right by COEFF_FRAC and saturate to DATA_WIDTH.
REQ-022 In ROUND, SHALL shift section state: x2<=x1, x1<=x, y2<=y1, y1<=saturated y.
REQ-023 SHALL OR overflow/underflow over all sections of one sample and present them with valid_out.
REQ-024 SHALL set latency from accept edge to valid_out high at 6*NUM_SECTIONS+1 cycles (19 at default); valid_out SHALL be a one-cycle pulse.
REQ-025 SHALL hold ready low from the cycle after accept until the OUT cycle; ready SHALL be high in OUT, allowing back-to-back accept.
REQ-026 SHALL ignore valid_in while ready is low; no buffering.
REQ-027 On a bypass accept: iir_out=iir_in and valid_out high in the next cycle, flags 0, section state untouched.
REQ-028 SHALL accept coefficient writes only when the state is IDLE; otherwise the write SHALL be dropped and coeff_wr_err pulsed.
REQ-029 SHALL hold iir_out and flags between valid_out pulses.

Reset
REQ-030 On rst: state IDLE, ready 1, valid_out/overflow/underflow/coeff_wr_err 0, iir_out 0, all x/y state 0.
REQ-031 On rst: every b0 = 2^COEFF_FRAC (1.0), all other coefficients 0, giving identity.
REQ-032 A reset mid-operation SHALL abort the sample with no valid_out produced.

Configuration
REQ-033 With IIR_SAT_CNT_EN defined, SHALL add output sat_count (16-bit), counting samples with overflow|underflow, saturating at 0xFFFF, cleared by rst.
REQ-034 Without IIR_SAT_CNT_EN, the port and its counter SHALL be absent.

Structure
REQ-035 Package iir_pkg SHALL hold the FSM state enum, the coefficient index constants (B0..A2 = 0..4) and a coefficients-per-section constant of 5.
REQ-036 Rounding/saturation SHALL be sub-module iir_round_sat (combinational; acc in; data, overflow, underflow out).

Verification
REQ-037 Reset defaults, iir_in=0x4000 accepted -> iir_out=0x4000, valid_out exactly 19 cycles after accept.
REQ-038 Section 0 b0=0x20000 (0.5), impulse 0x4000 then zeros -> first output 0x2000, then 0x0000.
REQ-039 Section 0 b0=0x7FFFF, iir_in=0x7FFF -> iir_out=0x7FFF, overflow=1; iir_in=0x8000 -> 0x8000, underflow=1.
REQ-040 valid_in and coeff_wr_en pulsed mid-computation -> no extra valid_out, coeff_wr_err=1 for one cycle, coeff_rd_data unchanged.
REQ-041 bypass=1, iir_in=0x1234 -> iir_out=0x1234 next cycle; a following filtered sample matches the model with state unaltered.
REQ-042 rst asserted at cycle 7 of a sample -> no valid_out; after release, iir_in=0x4000 -> 0x4000.
